// File: rtl/g_lut_arbiter_pkg.sv
// Shared constants and helpers for the G_LUT ROM arbiter.
package g_lut_arbiter_pkg;

  localparam int unsigned DEF_ADDR_WIDTH = 10;
  localparam int unsigned DEF_DATA_WIDTH = 8;

  // Legal ROM read latencies: bare array, or array plus output register.
  localparam int unsigned ROM_LAT_NOREG = 1;
  localparam int unsigned ROM_LAT_OREG  = 2;

  // Ceiling log2; callers guard n < 2 themselves where a zero width would hurt.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/g_lut_arbiter_rr_arbiter.sv
// Combinational round-robin selector: first asserted request at or after ptr.
module g_lut_arbiter_rr_arbiter #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    winner,
  output logic               found
);

  always_comb begin : sel
    int unsigned idx;
    idx    = 0;
    grant  = '0;
    winner = '0;
    found  = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req[ID_W'(idx)]) begin
        found               = 1'b1;
        grant[ID_W'(idx)]   = 1'b1;
        winner              = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/g_lut_arbiter.sv
// Round-robin, burst-locked sharing of the single-port G_LUT ROM between
// pixel-path requesters, with a tagged response pipeline matched to ROM latency.
module g_lut_arbiter
  import g_lut_arbiter_pkg::*;
#(
  parameter  int unsigned ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter  int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter  int unsigned NUM_REQ     = 3,
  parameter  int unsigned ROM_LATENCY = ROM_LAT_NOREG,
  parameter  int unsigned MAX_BURST   = 4,
  localparam int unsigned ID_W        = clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic [ADDR_WIDTH-1:0]         rom_addr,
  input  logic [DATA_WIDTH-1:0]         rom_rd_data,
  output logic [ID_W-1:0]               grant_id
);

  localparam int unsigned BCNT_W = (MAX_BURST > 1) ? clog2(MAX_BURST) : 1;
  localparam int unsigned DEPTH  = 1 + ROM_LATENCY;

  logic [ID_W-1:0]                  ptr;
  logic [ID_W-1:0]                  owner;
  logic                             owner_vld;
  logic [BCNT_W-1:0]                bcnt;
  logic [DEPTH-1:0][NUM_REQ-1:0]    tag_q;

  logic [NUM_REQ-1:0]               rr_grant;
  logic [ID_W-1:0]                  rr_winner;
  logic                             rr_found;
  logic                             hold_c;
  logic                             xfer_c;
  logic [ID_W-1:0]                  gnt_id_c;
  logic [ID_W-1:0]                  ptr_nxt_c;
  logic [ADDR_WIDTH-1:0]            gnt_addr_c;
  logic [ADDR_WIDTH-1:0]            addr_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign addr_arr[i] = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
  end

  g_lut_arbiter_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr (
    .req    (req_valid),
    .ptr    (ptr),
    .grant  (rr_grant),
    .winner (rr_winner),
    .found  (rr_found)
  );

  // Owner keeps the ROM while it stays valid and its burst has room left.
  always_comb begin
    hold_c     = owner_vld && req_valid[owner] && ((32'(bcnt) + 32'd1) < MAX_BURST);
    req_ready  = hold_c ? (NUM_REQ'(1) << owner) : rr_grant;
    xfer_c     = hold_c || rr_found;
    gnt_id_c   = hold_c ? owner : rr_winner;
    gnt_addr_c = addr_arr[gnt_id_c];
    ptr_nxt_c  = (32'(rr_winner) == NUM_REQ - 1) ? '0 : rr_winner + ID_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= '0;
      bcnt      <= '0;
      owner     <= '0;
      owner_vld <= 1'b0;
      rom_addr  <= '0;
      grant_id  <= '0;
      tag_q     <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
    end else begin
      if (hold_c) begin
        bcnt <= bcnt + BCNT_W'(1);
      end else if (rr_found) begin
        ptr   <= ptr_nxt_c;
        bcnt  <= '0;
        owner <= rr_winner;
      end
      owner_vld <= xfer_c;
      if (xfer_c) begin
        rom_addr <= gnt_addr_c;
        grant_id <= gnt_id_c;
      end
      // Tag walks alongside the ROM read; idle cycles shift in zeros.
      tag_q     <= {tag_q[DEPTH-2:0], req_ready};
      rsp_valid <= tag_q[DEPTH-1];
      if (|tag_q[DEPTH-1]) rsp_data <= rom_rd_data;
    end
  end

endmodule

// File: tb/tb_g_lut_arbiter.sv
// Scoreboard bench: three arbiter builds (burst 4, burst 1, ROM latency 2) share one stimulus.
module tb_g_lut_arbiter;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 8;
  localparam int unsigned NR = 3;
  localparam int unsigned NI = 3;

  typedef struct {
    int         inst;
    int         due;
    logic [2:0] tag;
    logic [7:0] data;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req_valid;
  logic [NR*AW-1:0]  req_addr;
  logic [NR-1:0]     ready  [NI];
  logic [NR-1:0]     rvld   [NI];
  logic [DW-1:0]     rdata  [NI];
  logic [AW-1:0]     raddr  [NI];
  logic [1:0]        gid    [NI];
  logic [DW-1:0]     rom_q1 [NI];
  logic [DW-1:0]     rom_q2 [NI];

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  bit   chk_en = 1'b0;
  exp_t sb [$];

  int         ptr_m    [NI];
  int         bcnt_m   [NI];
  int         own_m    [NI];
  bit         own_v    [NI];
  logic [9:0] exp_addr [NI];
  logic [1:0] exp_gid  [NI];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ROM model: byte = addr[7:0] ^ 0x5A, one or two registered stages.
  always @(posedge clk) begin
    for (int k = 0; k < NI; k++) begin
      rom_q1[k] <= raddr[k][7:0] ^ 8'h5A;
      rom_q2[k] <= rom_q1[k];
    end
  end

  g_lut_arbiter #(.NUM_REQ(3), .ROM_LATENCY(1), .MAX_BURST(4)) dut_b4 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(ready[0]), .rsp_valid(rvld[0]), .rsp_data(rdata[0]),
    .rom_addr(raddr[0]), .rom_rd_data(rom_q1[0]), .grant_id(gid[0]));

  g_lut_arbiter #(.NUM_REQ(3), .ROM_LATENCY(1), .MAX_BURST(1)) dut_b1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(ready[1]), .rsp_valid(rvld[1]), .rsp_data(rdata[1]),
    .rom_addr(raddr[1]), .rom_rd_data(rom_q1[1]), .grant_id(gid[1]));

  g_lut_arbiter #(.NUM_REQ(3), .ROM_LATENCY(2), .MAX_BURST(4)) dut_l2 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(ready[2]), .rsp_valid(rvld[2]), .rsp_data(rdata[2]),
    .rom_addr(raddr[2]), .rom_rd_data(rom_q2[2]), .grant_id(gid[2]));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset(input int k);
    ptr_m[k]    = 0;
    bcnt_m[k]   = 0;
    own_m[k]    = 0;
    own_v[k]    = 1'b0;
    exp_addr[k] = '0;
    exp_gid[k]  = '0;
  endtask

  // Reference arbiter plus scoreboard push/pop for one build.
  task automatic model_step(input int k);
    int         mb, lat, g, idx;
    bit         hold, hit;
    logic [2:0] eg, ev;
    logic [7:0] ed;
    logic [9:0] a;
    exp_t       e;
    mb  = (k == 1) ? 1 : 4;
    lat = (k == 2) ? 2 : 1;

    check_eq($sformatf("rom_addr[%0d]", k), 32'(raddr[k]), 32'(exp_addr[k]));
    check_eq($sformatf("grant_id[%0d]", k), 32'(gid[k]), 32'(exp_gid[k]));

    hit = 1'b0; ev = '0; ed = '0;
    for (int j = 0; j < sb.size(); j++) begin
      if (sb[j].inst == k && sb[j].due == cyc) begin
        hit = 1'b1; ev = sb[j].tag; ed = sb[j].data;
        sb.delete(j);
        break;
      end
    end
    check_eq($sformatf("rsp_valid[%0d]", k), 32'(rvld[k]), 32'(ev));
    if (hit) check_eq($sformatf("rsp_data[%0d]", k), 32'(rdata[k]), 32'(ed));

    g    = -1;
    hold = own_v[k] && req_valid[own_m[k]] && (bcnt_m[k] < mb - 1);
    if (hold) g = own_m[k];
    else begin
      for (int j = 0; j < int'(NR); j++) begin
        idx = (ptr_m[k] + j) % int'(NR);
        if (g < 0 && req_valid[idx]) g = idx;
      end
    end
    eg = (g >= 0) ? 3'(1 << g) : 3'b000;
    check_eq($sformatf("req_ready[%0d]", k), 32'(ready[k]), 32'(eg));

    if (rst) begin
      model_reset(k);
      for (int j = sb.size() - 1; j >= 0; j--) if (sb[j].inst == k) sb.delete(j);
    end else if (g >= 0) begin
      if (hold) bcnt_m[k]++;
      else begin
        ptr_m[k]  = (g + 1) % int'(NR);
        bcnt_m[k] = 0;
        own_m[k]  = g;
      end
      own_v[k]    = 1'b1;
      a           = req_addr[g*AW +: AW];
      exp_addr[k] = a;
      exp_gid[k]  = 2'(g);
      e.inst = k; e.due = cyc + 2 + lat; e.tag = eg; e.data = a[7:0] ^ 8'h5A;
      sb.push_back(e);
    end else begin
      own_v[k] = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) for (int k = 0; k < NI; k++) model_step(k);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [2:0] v, input logic [9:0] a0, input logic [9:0] a1, input logic [9:0] a2);
    req_valid = v;
    req_addr  = {a2, a1, a0};
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    set_req(3'b000, 10'h0, 10'h0, 10'h0);
    step();
    rst = 1'b0;
  endtask

  initial begin
    logic [2:0] rot_tbl [4];
    rot_tbl = '{3'b001, 3'b010, 3'b100, 3'b001};
    rst = 1'b1;
    set_req(3'b000, 10'h0, 10'h0, 10'h0);
    for (int k = 0; k < NI; k++) model_reset(k);
    repeat (3) step();
    chk_en = 1'b1;
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      check_eq("reset_rsp_data", 32'(rdata[k]), 32'h0);
      check_eq("reset_rsp_valid", 32'(rvld[k]), 32'h0);
    end
    step();
    rst = 1'b0;

    // Single request from requester 1.
    set_req(3'b010, 10'h0, 10'h123, 10'h0);
    step();
    set_req(3'b000, 10'h0, 10'h123, 10'h0);
    @(negedge clk);
    check_eq("single_rom_addr", 32'(raddr[0]), 32'h123);
    repeat (6) step();

    // All valid after reset: burst-1 build must rotate 0,1,2,0.
    pulse_reset();
    set_req(3'b111, 10'h100, 10'h201, 10'h302);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("rotate_b1", 32'(ready[1]), 32'(rot_tbl[i]));
      step();
    end
    repeat (8) step();
    set_req(3'b000, 10'h100, 10'h201, 10'h302);
    repeat (6) step();

    // Requesters 0 and 2 streaming: burst-4 build alternates in runs of four.
    pulse_reset();
    set_req(3'b101, 10'h0AA, 10'h0, 10'h2CC);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check_eq("burst_b4", 32'(ready[0]), ((i / 4) % 2 == 0) ? 32'h1 : 32'h4);
      step();
    end
    set_req(3'b000, 10'h0AA, 10'h0, 10'h2CC);
    repeat (6) step();

    // Owner drops valid mid-burst; search moves on to requester 1.
    set_req(3'b011, 10'h033, 10'h144, 10'h0);
    repeat (2) step();
    set_req(3'b010, 10'h033, 10'h144, 10'h0);
    repeat (3) step();
    set_req(3'b000, 10'h033, 10'h144, 10'h0);
    repeat (6) step();

    // Reset one cycle after two handshakes: both reads must vanish.
    set_req(3'b001, 10'h011, 10'h0, 10'h0);
    step();
    set_req(3'b001, 10'h012, 10'h0, 10'h0);
    step();
    pulse_reset();
    set_req(3'b111, 10'h055, 10'h166, 10'h277);
    @(negedge clk);
    for (int k = 0; k < NI; k++) check_eq("post_reset_grant", 32'(ready[k]), 32'h1);
    step();
    set_req(3'b000, 10'h055, 10'h166, 10'h277);
    repeat (6) step();

    // Address walk on requester 0, including the 0x3FF -> 0x000 wrap.
    for (int i = 0; i < 1026; i++) begin
      set_req(3'b001, 10'(i), 10'h0, 10'h0);
      step();
    end
    set_req(3'b000, 10'h0, 10'h0, 10'h0);
    repeat (8) step();

    @(negedge clk);
    check_eq("scoreboard_drained", 32'(sb.size()), 32'h0);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
